// File: rtl/relay_chain_driver.sv
// Sweeps every switch pattern across a series relay chain, waits for the contacts to settle, and
// records the chain's final contact into a truth table. Optional verdict: RELAY_CHAIN_SELF_CHECK_EN.
module relay_chain_driver #(
    parameter int unsigned N             = 2,
    parameter int unsigned SETTLE_CYCLES = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic              chain_out,
    output logic [N-1:0]      switch,
    output logic              busy,
    output logic              done,
    output logic [(1<<N)-1:0] result,
    output logic              pass
);

    localparam int unsigned R  = 1 << N;
    localparam int unsigned CW = $clog2(SETTLE_CYCLES + 1);
    localparam logic [N:0]  LAST_IDX = (N+1)'(R - 1);

    typedef enum logic [2:0] {StIdle, StDrive, StSettle, StSample, StDone} state_e;

    state_e          state;
    logic [N:0]      idx;
    logic [CW-1:0]   cnt;
    logic [R-1:0]    result_smp;

    // Table including the bit being sampled this cycle, so the verdict sees the final pattern.
    always_comb begin
        result_smp                = result;
        result_smp[idx[N-1:0]]    = chain_out;
    end

`ifdef RELAY_CHAIN_SELF_CHECK_EN
    // Ideal series chain: contact closes only when every relay is energised.
    localparam logic [R-1:0] IDEAL = {1'b1, {(R-1){1'b0}}};
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= StIdle;
            idx    <= '0;
            cnt    <= '0;
            switch <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            result <= '0;
            pass   <= 1'b0;
        end else begin
            done <= 1'b0;
            if (abort && (state inside {StDrive, StSettle, StSample})) begin
                state  <= StIdle;
                switch <= '0;
                busy   <= 1'b0;
                pass   <= 1'b0;
            end else begin
                unique case (state)
                    StIdle: begin
                        if (start && !abort) begin
                            result <= '0;
                            idx    <= '0;
                            busy   <= 1'b1;
                            state  <= StDrive;
                        end
                    end
                    StDrive: begin
                        switch <= idx[N-1:0];
                        cnt    <= CW'(SETTLE_CYCLES);
                        state  <= StSettle;
                    end
                    StSettle: begin
                        cnt <= cnt - CW'(1);
                        if (cnt == CW'(1)) state <= StSample;
                    end
                    StSample: begin
                        result <= result_smp;
                        if (idx == LAST_IDX) begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
`ifdef RELAY_CHAIN_SELF_CHECK_EN
                            pass  <= (result_smp == IDEAL);
`else
                            pass  <= 1'b0;
`endif
                            state <= StDone;
                        end else begin
                            idx   <= idx + (N+1)'(1);
                            state <= StDrive;
                        end
                    end
                    StDone: begin
                        switch <= '0;
                        state  <= StIdle;
                    end
                    default: state <= StIdle;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_relay_chain_driver.sv
// Scoreboard bench for relay_chain_driver: a 2-relay/3-settle instance and a 1-relay/1-settle one,
// each fed by a behavioural chain model.
module tb_relay_chain_driver;

`ifdef RELAY_CHAIN_SELF_CHECK_EN
    localparam bit SC = 1'b1;
`else
    localparam bit SC = 1'b0;
`endif

    typedef struct {
        logic [3:0] res;
        logic       pass;
        int         cyc;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    int         cyc = 0;
    int         tests = 0;
    int         fails = 0;

    logic       start2 = 1'b0, abort2 = 1'b0, chain2;
    logic [1:0] switch2;
    logic       busy2, done2, pass2;
    logic [3:0] result2;
    int         mode2 = 0;

    logic       start1 = 1'b0, abort1 = 1'b0, chain1;
    logic [0:0] switch1;
    logic       busy1, done1, pass1;
    logic [1:0] result1;
    int         mode1 = 0;

    exp_t q2[$];
    exp_t q1[$];
    exp_t e2, e1;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // Behavioural chains: 0 healthy series, 1 relay 2 battery tied high, 2 relay 1 only, 3 inverted.
    always_comb begin
        case (mode2)
            1:       chain2 = switch2[1];
            2:       chain2 = switch2[0];
            3:       chain2 = ~switch2[0];
            default: chain2 = &switch2;
        endcase
        chain1 = (mode1 == 1) ? ~switch1[0] : switch1[0];
    end

    relay_chain_driver #(.N(2), .SETTLE_CYCLES(3)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .abort(abort2), .chain_out(chain2),
        .switch(switch2), .busy(busy2), .done(done2), .result(result2), .pass(pass2)
    );

    relay_chain_driver #(.N(1), .SETTLE_CYCLES(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort1), .chain_out(chain1),
        .switch(switch1), .busy(busy1), .done(done1), .result(result1), .pass(pass1)
    );

    task automatic chk(input string nm, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && done2) begin
            if (q2.size() == 0) begin
                chk("dut2_unexpected_done", 1, 0);
            end else begin
                e2 = q2.pop_front();
                chk("dut2_done_cycle", cyc, e2.cyc);
                chk("dut2_result", int'(result2), int'(e2.res));
                chk("dut2_pass", int'(pass2), int'(e2.pass));
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && done1) begin
            if (q1.size() == 0) begin
                chk("dut1_unexpected_done", 1, 0);
            end else begin
                e1 = q1.pop_front();
                chk("dut1_done_cycle", cyc, e1.cyc);
                chk("dut1_result", int'(result1), int'(e1.res));
                chk("dut1_pass", int'(pass1), int'(e1.pass));
            end
        end
    end

    task automatic sweep2(input int mode, input logic [3:0] res, input logic p);
        @(negedge clk);
        mode2 = mode;
        q2.push_back('{res: res, pass: p, cyc: cyc + 1 + 4 * 5});
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
    endtask

    task automatic sweep1(input int mode, input logic [1:0] res, input logic p);
        @(negedge clk);
        mode1 = mode;
        q1.push_back('{res: {2'b00, res}, pass: p, cyc: cyc + 1 + 2 * 3});
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
    endtask

    task automatic drain(input int n);
        repeat (n) @(negedge clk);
        chk("dut2_scoreboard_drained", q2.size(), 0);
        chk("dut1_scoreboard_drained", q1.size(), 0);
    endtask

    task automatic chk_zero2(input string nm);
        chk({nm, "_switch"}, int'(switch2), 0);
        chk({nm, "_busy"}, int'(busy2), 0);
        chk({nm, "_done"}, int'(done2), 0);
        chk({nm, "_result"}, int'(result2), 0);
        chk({nm, "_pass"}, int'(pass2), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        #12;
        chk_zero2("reset2");
        chk("reset1_outputs", int'({switch1, busy1, done1, result1, pass1}), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Healthy series chain and one with relay 2's battery tied high.
        sweep2(0, 4'b1000, SC);
        drain(25);
        chk("idle_switch_after_sweep", int'(switch2), 0);
        chk("idle_busy_after_sweep", int'(busy2), 0);
        sweep2(1, 4'b1100, 1'b0);
        drain(25);

        // start held high: exactly two sweeps, second starting one cycle after done.
        @(negedge clk);
        mode2 = 0;
        q2.push_back('{res: 4'b1000, pass: SC, cyc: cyc + 21});
        q2.push_back('{res: 4'b1000, pass: SC, cyc: cyc + 43});
        start2 = 1'b1;
        repeat (22) @(negedge clk);
        chk("held_start_idle_busy", int'(busy2), 0);
        chk("held_start_idle_switch", int'(switch2), 0);
        @(negedge clk);
        chk("held_start_second_busy", int'(busy2), 1);
        repeat (8) @(negedge clk);
        start2 = 1'b0;
        drain(30);

        // Abort during the settle of pattern 2.
        @(negedge clk);
        mode2 = 2;
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        repeat (12) @(negedge clk);
        abort2 = 1'b1;
        @(negedge clk);
        abort2 = 1'b0;
        chk("abort_busy", int'(busy2), 0);
        chk("abort_switch", int'(switch2), 0);
        chk("abort_result", int'(result2), 4'b0010);
        chk("abort_pass", int'(pass2), 0);
        drain(25);

        // start and abort together in IDLE: abort wins.
        @(negedge clk);
        start2 = 1'b1;
        abort2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        abort2 = 1'b0;
        chk("start_abort_busy", int'(busy2), 0);
        drain(5);

        // Asynchronous reset mid-settle of pattern 1, then a clean sweep.
        @(negedge clk);
        mode2 = 3;
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        repeat (7) @(negedge clk);
        chk("pre_reset_switch", int'(switch2), 1);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1 chk_zero2("async_reset");
        @(negedge clk);
        rst_n = 1'b1;
        sweep2(0, 4'b1000, SC);
        drain(25);

        // Single relay, one settle cycle.
        sweep1(1, 2'b01, 1'b0);
        drain(10);
        sweep1(0, 2'b10, SC);
        drain(10);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/relay_chain_driver.md
# relay_chain_driver

Clocked stimulus/response driver for a series chain of `our_relay` instances: it walks every switch pattern across the chain, waits for the contacts to settle, and samples the chain's final contact. It is the transmit/sample side of the series-relay interface, the counterpart of the relay chain that receives the switch inputs. It produces the chain's measured truth table so that relay-level gate builds (AND from series relays, and later OR and INV) can be characterised in simulation without a hand-written `initial` block.

## Interface

Parameters:
- `N`, default 2: number of relays (switch lines) in the chain, 1..8.
- `SETTLE_CYCLES`, default 3: clock cycles to wait after driving a pattern before sampling, at least 1.

Ports:
- `clk`, input, 1: the block's single clock.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `start`, input, 1: begin a sweep. Sampled only in IDLE.
- `abort`, input, 1: cancel a sweep in progress.
- `chain_out`, input, 1: final contact of the relay chain.
- `switch`, output, N: switch drive to relays; bit i drives relay i.
- `busy`, output, 1: high from DRIVE through SAMPLE.
- `done`, output, 1: one-cycle pulse when a sweep completes.
- `result`, output, 2**N: measured truth table; bit k holds `chain_out` sampled while `switch == k`.
- `pass`, output, 1: self-check verdict (see Configuration).

## Operation

States and transitions:
- **IDLE**: `switch = 0`. On `start`, clear `result` and the pattern index `idx`, then go to DRIVE.
- **DRIVE** (1 cycle): register `switch <= idx`, load the settle counter with `SETTLE_CYCLES`, go to SETTLE.
- **SETTLE**: decrement the counter each cycle. When it reaches 0, go to SAMPLE.
- **SAMPLE** (1 cycle): `result[idx] <= chain_out`.
  - If `idx == 2**N-1`, go to DONE.
  - Otherwise `idx <= idx+1` and go to DRIVE.
- **DONE** (1 cycle): `done = 1`, update `pass`, drive `switch <= 0`, go to IDLE.

Rules and boundary conditions:
- `idx` is N+1 bits wide so the terminal compare does not wrap. `result` holds its value until the next `start`.
- `start` is ignored outside IDLE.
- `start` and `abort` asserted in the same IDLE cycle: `abort` wins and the block stays in IDLE.
- `abort` in DRIVE, SETTLE or SAMPLE: go to IDLE next cycle with `switch <= 0`. No `done` pulse; `result` keeps the bits already sampled; `pass <= 0`.
- `abort` in DONE is ignored; the sweep completes.
- `chain_out` is sampled only in SAMPLE. Glitches during SETTLE have no effect.

Reset (`rst_n` low, asynchronous, any state, including mid-sweep):
- State goes to IDLE.
- `switch`, `busy`, `done`, `result`, `pass` and `idx` all go to 0.

## Timing

- All outputs are registered. `busy` is high exactly while in DRIVE, SETTLE or SAMPLE.
- `start` sampled high in cycle t: DRIVE in t+1, `switch` valid from t+2.
- Per pattern: 2 + SETTLE_CYCLES cycles. First sample at cycle t+2+SETTLE_CYCLES.
- `done` is high in cycle t+1 + 2**N × (2+SETTLE_CYCLES). `result` and `pass` are valid in that same cycle.
- Back-to-back sweeps: `start` is accepted one cycle after `done`.

## Configuration

- Macro: `RELAY_CHAIN_SELF_CHECK_EN`.
- Defined: the DONE state compares `result` against the ideal series chain (AND of all switches), i.e. `result == (1 << (2**N-1))`. `pass` is set to 1 on a match and 0 otherwise.
- Undefined: no comparator is built and `pass` is tied to 0. The measured table is still reported on `result`.

## Test plan

1. Sweep of a healthy 2-relay series chain, SETTLE_CYCLES=3, `start` pulsed → `done` at start+21 cycles, `result=4'b1000`, `pass=1` (macro defined).
2. Same sweep with relay 2's battery tied to 1 (chain_out = switch[1]) → `result=4'b1100`, `pass=0`.
3. `abort` raised during the SETTLE of pattern 2 → IDLE next cycle, `switch=0`, no `done`, `result[1:0]` retained, `result[3:2]=0`, `pass=0`.
4. `rst_n` pulled low mid-SETTLE, asynchronously between clock edges → all outputs read 0 immediately; after release, a new `start` runs a full, correct sweep.
5. `start` held high through an entire sweep → exactly one sweep; a second starts only when IDLE is re-entered, one cycle after `done`.
6. N=1, SETTLE_CYCLES=1, with chain_out driven as `~switch[0]` → `done` after 6 cycles, `result=2'b01`, `pass=0`. With the macro undefined, `pass=0` for the healthy chain as well.
